// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubble insertion
// Optional: define FWD_STATS_EN to add FWD_COUNT / BUBBLE_COUNT saturating statistics outputs.
module id_ex_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic               ID_VALID,
  input  logic [WIDTH-1:0]   ID_RS_DATA,
  input  logic [WIDTH-1:0]   ID_RT_DATA,
  input  logic [WIDTH-1:0]   ID_IMM,
  input  logic [REGADDR-1:0] ID_RS,
  input  logic [REGADDR-1:0] ID_RT,
  input  logic [REGADDR-1:0] ID_RD,
  input  logic               ID_ALUSRC,
  input  logic [2:0]         ID_ALUOP,
  input  logic               ID_REGWRITE,
  input  logic               ID_MEMREAD,
  input  logic               EXMEM_REGWRITE,
  input  logic [REGADDR-1:0] EXMEM_RD,
  input  logic [WIDTH-1:0]   EXMEM_RESULT,
  input  logic               MEMWB_REGWRITE,
  input  logic [REGADDR-1:0] MEMWB_RD,
  input  logic [WIDTH-1:0]   MEMWB_RESULT,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   EX_STORE_DATA,
  output logic [2:0]         EX_ALUOP,
  output logic [REGADDR-1:0] EX_RD,
  output logic               EX_REGWRITE,
  output logic               EX_MEMREAD,
  output logic               EX_VALID,
  output logic               LOAD_USE_HAZARD
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]        FWD_COUNT,
  output logic [31:0]        BUBBLE_COUNT
`endif
);

  logic               valid_q, valid_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q, memread_d;
  logic               alusrc_q, alusrc_d;
  logic [2:0]         aluop_q, aluop_d;
  logic [REGADDR-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [WIDTH-1:0]   rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;

  logic exmem_rs_hit, memwb_rs_hit, exmem_rt_hit, memwb_rt_hit;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  // Operand forwarding: youngest producer (EX/MEM) wins; register 0 is never forwarded.
  always_comb begin
    exmem_rs_hit = EXMEM_REGWRITE && (EXMEM_RD != '0) && (EXMEM_RD == rs_q);
    memwb_rs_hit = MEMWB_REGWRITE && (MEMWB_RD != '0) && (MEMWB_RD == rs_q);
    exmem_rt_hit = EXMEM_REGWRITE && (EXMEM_RD != '0) && (EXMEM_RD == rt_q);
    memwb_rt_hit = MEMWB_REGWRITE && (MEMWB_RD != '0) && (MEMWB_RD == rt_q);
    fwd_rs = exmem_rs_hit ? EXMEM_RESULT : (memwb_rs_hit ? MEMWB_RESULT : rs_data_q);
    fwd_rt = exmem_rt_hit ? EXMEM_RESULT : (memwb_rt_hit ? MEMWB_RESULT : rt_data_q);
  end

  // Load in EX feeding an operand of the ID instruction: freeze IF/ID and bubble this stage.
  always_comb begin
    LOAD_USE_HAZARD = ID_VALID && valid_q && memread_q && (rd_q != '0) &&
                      ((rd_q == ID_RS) || (rd_q == ID_RT));
  end

  // Outputs to the ALU and downstream stages.
  always_comb begin
    A             = fwd_rs;
    B             = alusrc_q ? imm_q : fwd_rt;
    EX_STORE_DATA = fwd_rt;
    EX_ALUOP      = aluop_q;
    EX_RD         = rd_q;
    EX_REGWRITE   = regwrite_q && valid_q;
    EX_MEMREAD    = memread_q && valid_q;
    EX_VALID      = valid_q;
  end

  // Next-state: flush > stall (refresh operands, hold control) > hazard bubble > load from ID.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    if (FLUSH || (!STALL && LOAD_USE_HAZARD)) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      alusrc_d   = 1'b0;
      aluop_d    = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
    end else if (STALL) begin
      rs_data_d = fwd_rs;
      rt_data_d = fwd_rt;
    end else begin
      valid_d    = ID_VALID;
      regwrite_d = ID_REGWRITE;
      memread_d  = ID_MEMREAD;
      alusrc_d   = ID_ALUSRC;
      aluop_d    = ID_ALUOP;
      rs_d       = ID_RS;
      rt_d       = ID_RT;
      rd_d       = ID_RD;
      rs_data_d  = ID_RS_DATA;
      rt_data_d  = ID_RT_DATA;
      imm_d      = ID_IMM;
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_count_q, fwd_count_d, bubble_count_q, bubble_count_d;

  // Saturating event counters: forwarded-operand cycles and self-inserted bubbles.
  always_comb begin
    fwd_count_d    = fwd_count_q;
    bubble_count_d = bubble_count_q;
    if (valid_q && (exmem_rs_hit || memwb_rs_hit || exmem_rt_hit || memwb_rt_hit) &&
        (fwd_count_q != 32'hFFFF_FFFF))
      fwd_count_d = fwd_count_q + 32'd1;
    if (LOAD_USE_HAZARD && !FLUSH && !STALL && (bubble_count_q != 32'hFFFF_FFFF))
      bubble_count_d = bubble_count_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      fwd_count_q    <= '0;
      bubble_count_q <= '0;
    end else begin
      fwd_count_q    <= fwd_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign FWD_COUNT    = fwd_count_q;
  assign BUBBLE_COUNT = bubble_count_q;
`endif

endmodule
